// File: rtl/regfile_wb_pkg.sv
// Shared types and defaults for the register file write-back queue.
//   wb_state_e : write-port sequencer states
//   wb_entry_t : one queued result (destination address + data)
package regfile_wb_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold
  } wb_state_e;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] address;
    logic [DATA_W_DEF-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular FIFO holding pending register writes.
//   clk_i, rst_ni       : clock, async active-low reset (clears occupancy)
//   push_i, push_*_i    : enqueue one entry at the tail
//   pop_i               : drop the head
//   head_*_o, next_*_o  : peek at the head and the entry behind it
//   count_o             : occupied entries
//   occ_valid_o/occ_address_o : per-slot occupancy and address, for hazard compares
module wb_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             push_i,
  input  logic [ADDR_W-1:0]                push_address_i,
  input  logic [DATA_W-1:0]                push_data_i,
  input  logic                             pop_i,
  output logic [ADDR_W-1:0]                head_address_o,
  output logic [DATA_W-1:0]                head_data_o,
  output logic [ADDR_W-1:0]                next_address_o,
  output logic [DATA_W-1:0]                next_data_o,
  output logic [$clog2(DEPTH):0]           count_o,
  output logic [DEPTH-1:0]                 occ_valid_o,
  output logic [DEPTH-1:0][ADDR_W-1:0]     occ_address_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [ADDR_W-1:0] mem_address_q [DEPTH];
  logic [DATA_W-1:0] mem_data_q    [DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   next_ptr;
  logic [PtrW-1:0]   rel;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    rd_ptr_d = pop_i  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    wr_ptr_d = push_i ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    count_d  = count_q + CntW'(push_i) - CntW'(pop_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_address_q[wr_ptr_q] <= push_address_i;
      mem_data_q[wr_ptr_q]    <= push_data_i;
    end
  end

  assign next_ptr       = rd_ptr_q + PtrW'(1);
  assign head_address_o = mem_address_q[rd_ptr_q];
  assign head_data_o    = mem_data_q[rd_ptr_q];
  assign next_address_o = mem_address_q[next_ptr];
  assign next_data_o    = mem_data_q[next_ptr];
  assign count_o        = count_q;

  // A slot is live when its distance from the head is below the count.
  always_comb begin
    rel = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rel              = PtrW'(i) - rd_ptr_q;
      occ_valid_o[i]   = ({1'b0, rel} < count_q);
      occ_address_o[i] = mem_address_q[i];
    end
  end

endmodule

// File: rtl/regfile_writeback_queue.sv
// Write-side companion of the 32x32 register file. Accepts ALU and load
// results, serialises them and drives the register file write port with a
// glitch-free registered strobe (SETUP / STROBE / HOLD per write).
//   Clk, Reset_n              : clock, async active-low reset
//   Alu_*/Mem_*               : valid/ready result inputs (load has priority)
//   C_Address, C_Data, Write  : register file write port, all from flops
//   Query_A/B, Hazard_A/B     : decode source queries against pending writes
//   Empty, Count              : occupancy including the write in flight
module regfile_writeback_queue
  import regfile_wb_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    Alu_Valid,
  output logic                    Alu_Ready,
  input  logic [ADDR_W-1:0]       Alu_Address,
  input  logic [DATA_W-1:0]       Alu_Data,
  input  logic                    Mem_Valid,
  output logic                    Mem_Ready,
  input  logic [ADDR_W-1:0]       Mem_Address,
  input  logic [DATA_W-1:0]       Mem_Data,
  output logic [ADDR_W-1:0]       C_Address,
  output logic [DATA_W-1:0]       C_Data,
  output logic                    Write,
  input  logic [ADDR_W-1:0]       Query_A,
  input  logic [ADDR_W-1:0]       Query_B,
  output logic                    Hazard_A,
  output logic                    Hazard_B,
  output logic                    Empty,
  output logic [$clog2(DEPTH):0]  Count
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  wb_state_e                   state_q;
  logic                        full;
  logic                        mem_fire, alu_fire, push, pop;
  logic [ADDR_W-1:0]           push_address;
  logic [DATA_W-1:0]           push_data;
  logic [ADDR_W-1:0]           head_address, next_address;
  logic [DATA_W-1:0]           head_data, next_data;
  logic [CntW-1:0]             count;
  logic [DEPTH-1:0]            occ_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] occ_address;

  // Ready depends only on the registered count, never on this cycle's pop.
  assign full      = (count == CntW'(DEPTH));
  assign Mem_Ready = !full;
  assign Alu_Ready = !full && !Mem_Valid;
  assign mem_fire  = Mem_Valid && Mem_Ready;
  assign alu_fire  = Alu_Valid && Alu_Ready;

  assign push_address = mem_fire ? Mem_Address : Alu_Address;
  assign push_data    = mem_fire ? Mem_Data    : Alu_Data;
  // Writes to r0 complete the handshake but are dropped here.
  assign push = (mem_fire || alu_fire) && (push_address != '0);
  assign pop  = (state_q == StHold);

  wb_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk_i          (Clk),
    .rst_ni         (Reset_n),
    .push_i         (push),
    .push_address_i (push_address),
    .push_data_i    (push_data),
    .pop_i          (pop),
    .head_address_o (head_address),
    .head_data_o    (head_data),
    .next_address_o (next_address),
    .next_data_o    (next_data),
    .count_o        (count),
    .occ_valid_o    (occ_valid),
    .occ_address_o  (occ_address)
  );

  // Write-port sequencer. The head stays in the FIFO (and visible to the
  // hazard logic) until the HOLD pop; the entry behind it is loaded
  // directly on HOLD -> SETUP so back-to-back writes have no idle gap.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= StIdle;
      C_Address <= '0;
      C_Data    <= '0;
      Write     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          Write <= 1'b0;
          if (count != '0) begin
            state_q   <= StSetup;
            C_Address <= head_address;
            C_Data    <= head_data;
          end
        end
        StSetup: begin
          state_q <= StStrobe;
          Write   <= 1'b1;
        end
        StStrobe: begin
          state_q <= StHold;
          Write   <= 1'b0;
        end
        StHold: begin
          Write <= 1'b0;
          if (count > CntW'(1)) begin
            state_q   <= StSetup;
            C_Address <= next_address;
            C_Data    <= next_data;
          end else begin
            state_q <= StIdle;
          end
        end
      endcase
    end
  end

  always_comb begin
    Hazard_A = 1'b0;
    Hazard_B = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (occ_valid[i] && (occ_address[i] == Query_A)) Hazard_A = 1'b1;
      if (occ_valid[i] && (occ_address[i] == Query_B)) Hazard_B = 1'b1;
    end
    if (Query_A == '0) Hazard_A = 1'b0;
    if (Query_B == '0) Hazard_B = 1'b0;
  end

  assign Empty = (count == '0);
  assign Count = count;

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Bench for regfile_writeback_queue. The reference model keeps every
// accepted write with its acceptance edge and derives its schedule by
// arithmetic: SETUP edge = max(accept + 1, previous pop edge), strobe
// high after SETUP + 1, pop at SETUP + 3.
module tb_regfile_writeback_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b0;
  logic              Alu_Valid = 1'b0, Mem_Valid = 1'b0;
  logic              Alu_Ready, Mem_Ready;
  logic [ADDR_W-1:0] Alu_Address = '0, Mem_Address = '0;
  logic [DATA_W-1:0] Alu_Data = '0, Mem_Data = '0;
  logic [ADDR_W-1:0] C_Address;
  logic [DATA_W-1:0] C_Data;
  logic              Write;
  logic [ADDR_W-1:0] Query_A = '0, Query_B = '0;
  logic              Hazard_A, Hazard_B, Empty;
  logic [$clog2(DEPTH):0] Count;

  always #5 Clk = ~Clk;

  regfile_writeback_queue #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Alu_Valid   (Alu_Valid),
    .Alu_Ready   (Alu_Ready),
    .Alu_Address (Alu_Address),
    .Alu_Data    (Alu_Data),
    .Mem_Valid   (Mem_Valid),
    .Mem_Ready   (Mem_Ready),
    .Mem_Address (Mem_Address),
    .Mem_Data    (Mem_Data),
    .C_Address   (C_Address),
    .C_Data      (C_Data),
    .Write       (Write),
    .Query_A     (Query_A),
    .Query_B     (Query_B),
    .Hazard_A    (Hazard_A),
    .Hazard_B    (Hazard_B),
    .Empty       (Empty),
    .Count       (Count)
  );

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          acc;
    int          start;
    int          pop;
  } ent_t;

  ent_t        pend[$];
  int          total = 0;
  int          bad = 0;
  int          n = 0;
  int          last_pop = 0;
  logic [31:0] rf_dut [32];
  logic [31:0] rf_exp [32];

  // Register file stand-in: captures on the Write rising edge.
  always @(posedge Write) if (C_Address != '0) rf_dut[C_Address] = C_Data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    foreach (pend[i]) if (pend[i].acc <= n && pend[i].pop > n) c++;
    return c;
  endfunction

  function automatic logic m_hazard(input int q);
    if (q == 0) return 1'b0;
    foreach (pend[i]) if (pend[i].acc <= n && pend[i].pop > n && pend[i].addr == q) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_write();
    foreach (pend[i]) if (pend[i].start + 1 == n) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_add(input int a, input logic [31:0] d);
    ent_t e;
    e.addr  = a;
    e.data  = d;
    e.acc   = n + 1;
    e.start = (e.acc + 1 > last_pop) ? e.acc + 1 : last_pop;
    e.pop   = e.start + 3;
    last_pop = e.pop;
    pend.push_back(e);
  endfunction

  task automatic post_check();
    int c;
    c = m_count();
    check("count", 64'(Count), 64'(c));
    check("empty", 64'(Empty), 64'(c == 0));
    check("write", 64'(Write), 64'(m_write()));
    foreach (pend[i]) begin
      if (n >= pend[i].start && n <= pend[i].start + 2) begin
        check("c_address", 64'(C_Address), 64'(pend[i].addr));
        check("c_data", 64'(C_Data), 64'(pend[i].data));
      end
      if (pend[i].start + 1 == n) begin
        rf_exp[pend[i].addr] = pend[i].data;
        check("regfile", 64'(rf_dut[pend[i].addr]), 64'(rf_exp[pend[i].addr]));
      end
    end
    while (pend.size() > 0 && pend[0].pop <= n) void'(pend.pop_front());
  endtask

  // One clock: drive inputs, check ready/hazard, clock, check results.
  task automatic step(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                      input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic [4:0] qa, input logic [4:0] qb, output logic took_alu);
    int   c;
    logic emr, ear;
    Mem_Valid = mv; Mem_Address = ma; Mem_Data = md;
    Alu_Valid = av; Alu_Address = aa; Alu_Data = ad;
    Query_A = qa; Query_B = qb;
    #1;
    c   = m_count();
    emr = (c < DEPTH);
    ear = emr && !mv;
    check("mem_ready", 64'(Mem_Ready), 64'(emr));
    check("alu_ready", 64'(Alu_Ready), 64'(ear));
    check("hazard_a", 64'(Hazard_A), 64'(m_hazard(int'(qa))));
    check("hazard_b", 64'(Hazard_B), 64'(m_hazard(int'(qb))));
    took_alu = av && ear;
    if (mv && emr) begin
      if (ma != 0) m_add(int'(ma), md);
    end else if (av && ear) begin
      if (aa != 0) m_add(int'(aa), ad);
    end
    @(posedge Clk);
    n++;
    #1;
    post_check();
  endtask

  task automatic idle(input int cycles, input logic [4:0] qa, input logic [4:0] qb);
    logic t;
    for (int i = 0; i < cycles; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, qa, qb, t);
  endtask

  initial begin
    logic t;
    int   k;
    for (int i = 0; i < 32; i++) begin
      rf_dut[i] = '0;
      rf_exp[i] = '0;
    end

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    check("rst_write", 64'(Write), 64'(0));
    check("rst_count", 64'(Count), 64'(0));
    check("rst_empty", 64'(Empty), 64'(1));
    check("rst_c_address", 64'(C_Address), 64'(0));
    check("rst_c_data", 64'(C_Data), 64'(0));
    Reset_n = 1'b1;
    last_pop = n;

    // 1: single ALU write
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'hDEADBEEF, 5'd3, 5'd0, t);
    idle(5, 5'd3, 5'd0);

    // 2: load wins over ALU in the same cycle
    step(1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22, 5'd5, 5'd6, t);
    check("alu_blocked", 64'(t), 64'(0));
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h22, 5'd5, 5'd6, t);
    check("alu_taken", 64'(t), 64'(1));
    idle(8, 5'd5, 5'd6);

    // 3: five back-to-back ALU writes into a 4-deep queue
    for (int i = 0; i < 5; i++) begin
      k = 0;
      t = 1'b0;
      while (!t && k < 20) begin
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'(10 + i), 32'h100 + 32'(i), 5'd10, 5'd14, t);
        k++;
      end
      if (!t) check("fill_timeout", 64'(0), 64'(1));
    end
    idle(16, 5'd12, 5'd13);

    // 4: r0 writes are discarded
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, t);
    check("r0_handshake", 64'(t), 64'(1));
    idle(5, 5'd0, 5'd0);
    check("r0_stays_zero", 64'(rf_dut[0]), 64'(0));

    // 5: hazard tracking on a pending write to r7
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 5'd7, 5'd0, t);
    idle(6, 5'd7, 5'd0);

    // 6: reset during STROBE with three entries queued
    for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 32'd0, 1'b1, 5'(20 + i), 32'h200 + 32'(i),
                                     5'd20, 5'd21, t);
    k = 0;
    while (!m_write() && k < 10) begin
      idle(1, 5'd20, 5'd21);
      k++;
    end
    if (!m_write()) check("strobe_reached", 64'(0), 64'(1));
    check("pre_rst_count", 64'(Count), 64'(3));
    #2;
    Reset_n = 1'b0;
    #1;
    check("mid_rst_write", 64'(Write), 64'(0));
    check("mid_rst_count", 64'(Count), 64'(0));
    check("mid_rst_empty", 64'(Empty), 64'(1));
    pend.delete();
    @(posedge Clk); n++;
    @(posedge Clk); n++;
    #1;
    Reset_n = 1'b1;
    last_pop = n;
    idle(8, 5'd21, 5'd22);
    check("lost_entry", 64'(rf_dut[22]), 64'(0));

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), t);
    end
    idle(20, 5'd1, 5'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regfile_writeback_queue.md
Name: regfile_writeback_queue

Overview:
- Write-side companion of the CPU's 32x32 register file.
- Buffers results from the ALU and load paths, serialises them, and drives the register file write port (C_Address, C_Data, Write).
- Generates a clean Write strobe, because the register file captures on the Write rising edge.
- Reports pending-write hazards to decode so reads of in-flight registers stall.

Parameters:
DEPTH, 4, queue entries (power of 2, >=2)
DATA_W, 32, result data width
ADDR_W, 5, register address width

Ports:
Clk  in  1  system clock, rising edge
Reset_n  in  1  asynchronous active-low reset
Alu_Valid  in  1  ALU result offered
Alu_Ready  out  1  ALU result accepted when Alu_Valid && Alu_Ready
Alu_Address  in  ADDR_W  ALU destination register
Alu_Data  in  DATA_W  ALU result
Mem_Valid  in  1  load result offered
Mem_Ready  out  1  load result accepted when Mem_Valid && Mem_Ready
Mem_Address  in  ADDR_W  load destination register
Mem_Data  in  DATA_W  load data
C_Address  out  ADDR_W  register file write address
C_Data  out  DATA_W  register file write data
Write  out  1  register file write strobe, one cycle high per write
Query_A  in  ADDR_W  decode source A address
Query_B  in  ADDR_W  decode source B address
Hazard_A  out  1  pending write to Query_A
Hazard_B  out  1  pending write to Query_B
Empty  out  1  no queued or in-flight writes
Count  out  $clog2(DEPTH)+1  occupied entries, including in-flight

Behaviour:
- Reset (async, Reset_n=0): C_Address=0, C_Data=0, Write=0, state IDLE, Count=0, Empty=1, queue cleared.
  - Write drops immediately on reset, including mid-STROBE.
  - All queued entries are lost.
- Ready rules (from registered Count only; no path from the pop):
  - Mem_Ready = (Count<DEPTH).
  - Alu_Ready = (Count<DEPTH) && !Mem_Valid. Load has fixed priority; one enqueue per cycle.
- Address-0 results: handshake completes normally; the entry is discarded, never stored, and never strobed.
- FSM states: IDLE, SETUP, STROBE, HOLD.
  - IDLE: if Count>0, go to SETUP and register C_Address/C_Data from the queue head.
  - SETUP: Write=0 -> STROBE.
  - STROBE: Write=1 -> HOLD.
  - HOLD: Write=0; pop the head at the end of the cycle. If entries remain, go to SETUP and load the next head; else go to IDLE.
- Write and C_Address/C_Data come directly from flops; no glitches are permitted, because Write acts as an edge.
- C_Address/C_Data are stable from SETUP through HOLD inclusive, covering the register file's capture delay.
- Latency: accept at edge E0 -> SETUP at E1 -> Write high after E2 -> Write low after E3 -> pop at E4.
- Throughput: one write per 3 cycles. Back-to-back writes: HOLD->SETUP, no IDLE gap.
- Simultaneous enqueue and pop: Count unchanged; the new entry lands at the tail.
- Ordering: strict FIFO in acceptance order.
- Full (Count==DEPTH): both Ready=0. They rise the cycle after the HOLD pop.
- Hazards (combinational): Hazard_X=1 iff Query_X!=0 and any occupied entry holds Query_X, including the head being strobed. Clears the cycle after the pop.
- Empty = (Count==0).

Decomposition:
- Package regfile_wb_pkg holds:
  - state enum (IDLE, SETUP, STROBE, HOLD)
  - ADDR_W/DATA_W default constants
  - entry struct {address, data}
- Sub-module wb_fifo provides:
  - synchronous circular FIFO with head peek, push/pop, and Count
  - per-entry occupied address vector exported for the hazard compare

Test Plan:
1. ALU write (3, 0xDEADBEEF) into an empty queue -> C_Address=3 and C_Data=0xDEADBEEF from E1 to E4; Write=1 only between E2 and E3; register 3 reads 0xDEADBEEF; Empty=1 after E4.
2. Mem (5, 0x11) and ALU (6, 0x22) valid in the same cycle -> Mem accepted, Alu_Ready=0; ALU accepted next cycle; Write pulses for address 5 then 6, 3 cycles apart.
3. Five back-to-back ALU writes, DEPTH=4 -> Count=4 and Alu_Ready=0 after the 4th; 5th accepted the cycle after the first HOLD pop; all five are written in order.
4. ALU write (0, 0xFFFFFFFF) -> handshake completes, Count stays 0, no Write pulse, register 0 stays 0.
5. Pending write to 7 with Query_A=7 and Query_B=0 -> Hazard_A=1 until the cycle after its pop, Hazard_B=0 throughout.
6. Reset_n pulled low during STROBE with 3 entries queued -> Write=0 immediately, Count=0, Empty=1; after release, no writes are emitted.
